// File: rtl/cbus_mem_responder_if.sv
// Cache bus (cbus) connection between an initiator (cache) and a responder (memory).
// Request/response are packed structs; burst=0 is FIXED, burst=1 is INCR.
interface cbus_mem_responder_if;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [3:0]  len;
        logic        burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    cbus_req_t  creq;
    cbus_resp_t cresp;

    modport initiator (output creq, input cresp);
    modport responder (input creq, output cresp);
endinterface

// File: rtl/cbus_mem_responder.sv
// Word-addressed backing memory answering cbus single-beat and burst requests after a
// fixed first-beat latency; flags initiator protocol violations in a sticky bit.
module cbus_mem_responder #(
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned LATENCY   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    cbus_mem_responder_if.responder    bus,
    output logic                       proto_err
);
    localparam int unsigned IdxW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {StIdle, StWait, StBurst, StDone} state_e;

    state_e            state_q, state_d;
    logic [31:0]       addr_q;
    logic              is_write_q;
    logic [7:0]        strobe_q;
    logic [3:0]        len_q;
    logic              burst_q;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [3:0]        lat_q, lat_d;
    logic [3:0]        beat_q, beat_d;
    logic              proto_err_q, proto_err_d;
    logic              latch;
    logic              wr_en;
    logic              mismatch;

    logic [63:0] mem [MEM_WORDS];

    // Size is carried on the bus but only the latched strobe decides which bytes change.
    logic unused_req_bits;
    assign unused_req_bits = ^{bus.creq.size, bus.creq.strobe};

    assign mismatch = (bus.creq.addr != addr_q) || (bus.creq.is_write != is_write_q) ||
                      (bus.creq.len != len_q) || (bus.creq.burst != burst_q);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lat_d       = lat_q;
        beat_d      = beat_q;
        proto_err_d = proto_err_q;
        latch       = 1'b0;
        wr_en       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.creq.valid) begin
                    latch   = 1'b1;
                    lat_d   = 4'(LATENCY);
                    beat_d  = '0;
                    idx_d   = bus.creq.addr[3 +: IdxW];
                    state_d = (LATENCY > 0) ? StWait : StBurst;
                end
            end
            StWait: begin
                if (!bus.creq.valid) begin
                    proto_err_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    if (mismatch) proto_err_d = 1'b1;
                    if (lat_q <= 4'd1) state_d = StBurst;
                    else               lat_d   = lat_q - 4'd1;
                end
            end
            StBurst: begin
                if (!bus.creq.valid) begin
                    // Aborted beat is not written.
                    proto_err_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    if (mismatch) proto_err_d = 1'b1;
                    wr_en  = is_write_q;
                    beat_d = beat_q + 4'd1;
                    if (burst_q) idx_d = idx_q + IdxW'(1);
                    if (beat_q == len_q) state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            proto_err_q <= 1'b0;
            idx_q       <= '0;
            lat_q       <= '0;
            beat_q      <= '0;
            addr_q      <= '0;
            is_write_q  <= 1'b0;
            strobe_q    <= '0;
            len_q       <= '0;
            burst_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            proto_err_q <= proto_err_d;
            idx_q       <= idx_d;
            lat_q       <= lat_d;
            beat_q      <= beat_d;
            if (latch) begin
                addr_q     <= bus.creq.addr;
                is_write_q <= bus.creq.is_write;
                strobe_q   <= bus.creq.strobe;
                len_q      <= bus.creq.len;
                burst_q    <= bus.creq.burst;
            end
        end
    end

    // Memory has no reset; contents survive a reset.
    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (strobe_q[i]) mem[idx_q][8*i +: 8] <= bus.creq.data[8*i +: 8];
            end
        end
    end

    assign bus.cresp.ready = (state_q == StBurst);
    assign bus.cresp.last  = (state_q == StBurst) && (beat_q == len_q);
    assign bus.cresp.data  = (state_q == StBurst) ? mem[idx_q] : 64'd0;
    assign proto_err       = proto_err_q;
endmodule

// File: tb/tb_cbus_mem_responder.sv
// Directed bench for cbus_mem_responder: reads, writes, bursts, wrap/alias, aborts,
// reset mid-burst, protocol mismatch and back-to-back spacing.
module tb_cbus_mem_responder;
    localparam int unsigned LAT   = 2;
    localparam bit          FIXED = 1'b0;
    localparam bit          INCR  = 1'b1;

    logic clk = 1'b0;
    logic reset;
    logic proto_err;

    cbus_mem_responder_if bus ();

    cbus_mem_responder #(
        .MEM_WORDS(4096),
        .LATENCY  (LAT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] wdata [16];
    logic [63:0] rdata [16];
    logic        rlast [16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one request from IDLE, captures beats, returns with the DUT back in IDLE.
    task automatic txn(input bit wr, input logic [31:0] addr, input logic [3:0] len,
                       input bit incr, input logic [7:0] strb, input int abort_at,
                       output int lat, output int nb, output bit to);
        bit done;
        lat = 0; nb = 0; to = 1'b0; done = 1'b0;
        bus.creq.valid    = 1'b1;
        bus.creq.is_write = wr;
        bus.creq.size     = 3'd3;
        bus.creq.addr     = addr;
        bus.creq.len      = len;
        bus.creq.burst    = incr;
        bus.creq.strobe   = strb;
        bus.creq.data     = wdata[0];
        do begin
            step();
            lat++;
        end while (!bus.cresp.ready && lat < 40);
        if (!bus.cresp.ready) to = 1'b1;
        while (!to && !done && bus.cresp.ready && nb < 16) begin
            rdata[nb] = bus.cresp.data;
            rlast[nb] = bus.cresp.last;
            if (nb == abort_at) begin
                bus.creq.valid = 1'b0;
                done = 1'b1;
            end else begin
                bus.creq.data = wdata[nb];
                nb++;
            end
            step();
        end
        bus.creq.valid = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.creq = '0;
        step();
        step();
        total++; if (bus.cresp.ready !== 1'b0) begin bad++;
            $display("FAIL reset_ready: got %b want 0", bus.cresp.ready); end
        total++; if (bus.cresp.last !== 1'b0) begin bad++;
            $display("FAIL reset_last: got %b want 0", bus.cresp.last); end
        total++; if (bus.cresp.data !== 64'd0) begin bad++;
            $display("FAIL reset_data: got %h want 0", bus.cresp.data); end
        total++; if (proto_err !== 1'b0) begin bad++;
            $display("FAIL reset_proto_err: got %b want 0", proto_err); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_single();
        int lat, nb;
        bit to;
        wdata[0] = 64'hDEADBEEF_00000001;
        txn(1'b1, 32'h80, 4'd0, FIXED, 8'hFF, -1, lat, nb, to);
        total++; if (to || nb != 1) begin bad++;
            $display("FAIL single_wr_beats: got %0d (to=%0b) want 1", nb, to); end
        txn(1'b0, 32'h80, 4'd0, FIXED, 8'h00, -1, lat, nb, to);
        total++; if (lat != LAT + 1) begin bad++;
            $display("FAIL single_rd_latency: got %0d want %0d", lat, LAT + 1); end
        total++; if (to || nb != 1) begin bad++;
            $display("FAIL single_rd_beats: got %0d (to=%0b) want 1", nb, to); end
        total++; if (rdata[0] !== 64'hDEADBEEF_00000001) begin bad++;
            $display("FAIL single_rd_data: got %h want deadbeef00000001", rdata[0]); end
        total++; if (rlast[0] !== 1'b1) begin bad++;
            $display("FAIL single_rd_last: got %b want 1", rlast[0]); end
    endtask

    task automatic test_incr_burst();
        int lat, nb;
        bit to;
        for (int k = 0; k < 16; k++) wdata[k] = 64'(k);
        txn(1'b1, 32'h200, 4'd15, INCR, 8'hFF, -1, lat, nb, to);
        total++; if (to || nb != 16) begin bad++;
            $display("FAIL incr_wr_beats: got %0d (to=%0b) want 16", nb, to); end
        for (int k = 0; k < 16; k++) rdata[k] = 'x;
        txn(1'b0, 32'h200, 4'd15, INCR, 8'hFF, -1, lat, nb, to);
        total++; if (to || nb != 16) begin bad++;
            $display("FAIL incr_rd_beats: got %0d (to=%0b) want 16", nb, to); end
        for (int k = 0; k < 16; k++) begin
            total++; if (rdata[k] !== 64'(k) || rlast[k] !== (k == 15)) begin bad++;
                $display("FAIL incr_rd_beat%0d: got data=%h last=%b want data=%h last=%b",
                         k, rdata[k], rlast[k], 64'(k), (k == 15)); end
        end
        total++; if (proto_err !== 1'b0) begin bad++;
            $display("FAIL clean_proto_err: got %b want 0", proto_err); end
    endtask

    task automatic test_partial_write();
        int lat, nb;
        bit to;
        wdata[0] = 64'h1111111111111111;
        txn(1'b1, 32'h28, 4'd0, FIXED, 8'hFF, -1, lat, nb, to);
        wdata[0] = 64'hAAAAAAAAAAAAAAAA;
        txn(1'b1, 32'h28, 4'd0, FIXED, 8'h0F, -1, lat, nb, to);
        txn(1'b0, 32'h28, 4'd0, FIXED, 8'h00, -1, lat, nb, to);
        total++; if (to || rdata[0] !== 64'h11111111AAAAAAAA) begin bad++;
            $display("FAIL partial_write: got %h want 11111111aaaaaaaa", rdata[0]); end
    endtask

    task automatic test_fixed_burst();
        int lat, nb;
        bit to;
        for (int k = 0; k < 4; k++) wdata[k] = 64'h50 + 64'(k);
        txn(1'b1, 32'h300, 4'd3, FIXED, 8'hFF, -1, lat, nb, to);
        txn(1'b0, 32'h300, 4'd1, FIXED, 8'h00, -1, lat, nb, to);
        total++; if (to || nb != 2 || rdata[0] !== 64'h53 || rdata[1] !== 64'h53) begin bad++;
            $display("FAIL fixed_burst: got nb=%0d %h %h want 2 53 53", nb, rdata[0], rdata[1]);
        end
    endtask

    task automatic test_wrap_alias();
        int lat, nb;
        bit to;
        for (int k = 0; k < 4; k++) wdata[k] = 64'h100 + 64'(k);
        txn(1'b1, 32'h7FF0, 4'd3, INCR, 8'hFF, -1, lat, nb, to);
        txn(1'b0, 32'h8000, 4'd0, FIXED, 8'h00, -1, lat, nb, to);
        total++; if (to || rdata[0] !== 64'h102) begin bad++;
            $display("FAIL alias_word0: got %h want 102", rdata[0]); end
        txn(1'b0, 32'h8, 4'd0, FIXED, 8'h00, -1, lat, nb, to);
        total++; if (to || rdata[0] !== 64'h103) begin bad++;
            $display("FAIL wrap_word1: got %h want 103", rdata[0]); end
        txn(1'b0, 32'h7FF0, 4'd3, INCR, 8'h00, -1, lat, nb, to);
        for (int k = 0; k < 4; k++) begin
            total++; if (to || rdata[k] !== 64'h100 + 64'(k)) begin bad++;
                $display("FAIL wrap_rd_beat%0d: got %h want %h", k, rdata[k], 64'h100 + 64'(k));
            end
        end
    endtask

    task automatic test_back_to_back();
        int wait_cnt, gap;
        bus.creq.valid    = 1'b1;
        bus.creq.is_write = 1'b0;
        bus.creq.addr     = 32'h28;
        bus.creq.len      = 4'd0;
        bus.creq.burst    = FIXED;
        wait_cnt = 0;
        do begin step(); wait_cnt++; end while (!bus.cresp.ready && wait_cnt < 40);
        gap = 0;
        do begin step(); gap++; end while (!bus.cresp.ready && gap < 40);
        total++; if (gap - 1 != LAT + 2) begin bad++;
            $display("FAIL b2b_gap: got %0d idle cycles want %0d", gap - 1, LAT + 2); end
        total++; if (bus.cresp.data !== 64'h11111111AAAAAAAA) begin bad++;
            $display("FAIL b2b_data: got %h want 11111111aaaaaaaa", bus.cresp.data); end
        bus.creq.valid = 1'b0;
        step();
        step();
    endtask

    task automatic test_abort();
        int lat, nb;
        bit to;
        for (int k = 0; k < 16; k++) wdata[k] = 64'hEE;
        txn(1'b1, 32'h400, 4'd15, INCR, 8'hFF, -1, lat, nb, to);
        for (int k = 0; k < 16; k++) wdata[k] = 64'hA0 + 64'(k);
        txn(1'b1, 32'h400, 4'd15, INCR, 8'hFF, 4, lat, nb, to);
        total++; if (to || nb != 4) begin bad++;
            $display("FAIL abort_beats: got %0d want 4", nb); end
        total++; if (proto_err !== 1'b1) begin bad++;
            $display("FAIL abort_proto_err: got %b want 1", proto_err); end
        total++; if (bus.cresp.ready !== 1'b0) begin bad++;
            $display("FAIL abort_ready: got %b want 0", bus.cresp.ready); end
        txn(1'b0, 32'h400, 4'd15, INCR, 8'h00, -1, lat, nb, to);
        total++; if (lat != LAT + 1) begin bad++;
            $display("FAIL abort_then_idle_latency: got %0d want %0d", lat, LAT + 1); end
        for (int k = 0; k < 16; k++) begin
            total++; if (rdata[k] !== ((k < 4) ? 64'hA0 + 64'(k) : 64'hEE)) begin bad++;
                $display("FAIL abort_mem%0d: got %h want %h", k, rdata[k],
                         (k < 4) ? 64'hA0 + 64'(k) : 64'hEE); end
        end
    endtask

    task automatic test_reset_mid_burst();
        int lat, nb, wait_cnt;
        bit to;
        bus.creq.valid    = 1'b1;
        bus.creq.is_write = 1'b0;
        bus.creq.addr     = 32'h200;
        bus.creq.len      = 4'd15;
        bus.creq.burst    = INCR;
        wait_cnt = 0;
        do begin step(); wait_cnt++; end while (!bus.cresp.ready && wait_cnt < 40);
        total++; if (!bus.cresp.ready) begin bad++;
            $display("FAIL rst_mid_start: got ready=%b want 1", bus.cresp.ready); end
        step();
        step();
        reset = 1'b0;
        step();
        total++; if (bus.cresp.ready !== 1'b0) begin bad++;
            $display("FAIL rst_mid_ready: got %b want 0", bus.cresp.ready); end
        total++; if (proto_err !== 1'b0) begin bad++;
            $display("FAIL rst_mid_proto_err: got %b want 0", proto_err); end
        reset = 1'b1;
        bus.creq.valid = 1'b0;
        step();
        txn(1'b0, 32'h28, 4'd0, FIXED, 8'h00, -1, lat, nb, to);
        total++; if (to || rdata[0] !== 64'h11111111AAAAAAAA) begin bad++;
            $display("FAIL rst_mem_retained: got %h want 11111111aaaaaaaa", rdata[0]); end
    endtask

    task automatic test_proto_mismatch();
        int wait_cnt, nb;
        bus.creq.valid    = 1'b1;
        bus.creq.is_write = 1'b0;
        bus.creq.addr     = 32'h200;
        bus.creq.len      = 4'd1;
        bus.creq.burst    = INCR;
        step();
        bus.creq.addr = 32'h208;
        wait_cnt = 0;
        while (!bus.cresp.ready && wait_cnt < 40) begin step(); wait_cnt++; end
        nb = 0;
        while (bus.cresp.ready && nb < 16) begin
            rdata[nb] = bus.cresp.data;
            nb++;
            step();
        end
        bus.creq.valid = 1'b0;
        step();
        total++; if (nb != 2 || rdata[0] !== 64'd0 || rdata[1] !== 64'd1) begin bad++;
            $display("FAIL mismatch_latched: got nb=%0d %h %h want 2 0 1",
                     nb, rdata[0], rdata[1]); end
        total++; if (proto_err !== 1'b1) begin bad++;
            $display("FAIL mismatch_proto_err: got %b want 1", proto_err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_incr_burst();
        test_partial_write();
        test_fixed_burst();
        test_wrap_alias();
        test_back_to_back();
        test_abort();
        test_reset_mid_burst();
        test_proto_mismatch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
